wfifo_write_arbiter: RTL



---
 rtl/wfifo_write_arbiter_if.sv | 36 +++
 rtl/wfifo_write_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/wfifo_write_arbiter_if.sv
// wfifo_write_arbiter_if
//   Bundles the requester valid/ready/data bus and the FIFO write port of
//   the write-domain arbiter.
//   Ports (signals):
//     req_valid  [NUM_REQ]             per-requester word valid
//     req_data   [NUM_REQ*DATA_WIDTH]  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready  [NUM_REQ]             per-requester accept
//     full                             FIFO full flag (wclk domain)
//     w_en                             FIFO write enable
//     wdata      [DATA_WIDTH]          FIFO write data
//     grant_id   [$clog2(NUM_REQ)]     current winner index, 0 if none
//     busy                             burst lock held
//   Modports: master = arbiter side, slave = requesters/FIFO side.
interface wfifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         wdata;
  logic [$clog2(NUM_REQ)-1:0]    grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_data, full,
    output req_ready, w_en, wdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, full,
    input  req_ready, w_en, wdata, grant_id, busy
  );
endinterface

// File: rtl/wfifo_write_arbiter.sv
// wfifo_write_arbiter
//   Round-robin arbiter sharing the async FIFO write port among NUM_REQ
//   requesters. Every write is gated by the FIFO full flag, so a word is
//   only accepted (req_ready/w_en) when it can actually be written.
//   Optional burst lock (macro WFIFO_ARB_BURST_LOCK_EN, MAX_BURST > 1):
//   the first accepted requester keeps the port for up to MAX_BURST words.
//   Ports:
//     wclk  write-domain clock
//     wrst  synchronous active-high reset
//     bus   wfifo_write_arbiter_if.master (req_valid/req_data/req_ready,
//           full, w_en, wdata, grant_id, busy)
module wfifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                 wclk,
  input  logic                 wrst,
  wfifo_write_arbiter_if.master bus
);
  localparam int unsigned NR  = NUM_REQ;
  localparam int unsigned IDW = $clog2(NUM_REQ);

`ifdef WFIFO_ARB_BURST_LOCK_EN
  localparam bit BURST_EN = (MAX_BURST > 1);
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0] owner, owner_nxt;
  logic [7:0]     beat_cnt, beat_cnt_nxt;
  logic [IDW-1:0] winner;
  logic           has_winner;
  logic           xfer;
  logic           burst_done;

  // Cyclic successor; NUM_REQ need not be a power of two.
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    if (32'(i) == NR - 1) return '0;
    return i + 1'b1;
  endfunction

  // Winner selection: locked owner in BURST, cyclic scan from rr_ptr in IDLE.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] idx_w;
    has_winner = 1'b0;
    winner     = '0;
    idx        = 0;
    idx_w      = '0;
    if (BURST_EN && state == BURST) begin
      has_winner = bus.req_valid[owner];
      winner     = owner;
    end else begin
      for (int unsigned k = 0; k < NR; k++) begin
        idx   = (32'(rr_ptr) + k) % NR;
        idx_w = IDW'(idx);
        if (!has_winner && bus.req_valid[idx_w]) begin
          has_winner = 1'b1;
          winner     = idx_w;
        end
      end
    end
  end

  assign xfer       = has_winner && !bus.full;
  assign burst_done = ({1'b0, beat_cnt} + 9'd1) == 9'(MAX_BURST);

  // Next state and outputs.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    beat_cnt_nxt  = beat_cnt;
    bus.req_ready = '0;
    bus.w_en      = 1'b0;
    bus.wdata     = '0;
    bus.grant_id  = '0;
    bus.busy      = 1'b0;

    case (state)
      IDLE: begin
        if (xfer) begin
          if (BURST_EN) begin
            // Pointer moves only when the burst ends.
            state_nxt    = BURST;
            owner_nxt    = winner;
            beat_cnt_nxt = 8'd1;
          end else begin
            rr_ptr_nxt = next_idx(winner);
          end
        end
      end
      BURST: begin
        // full freezes the lock entirely, including an owner valid drop.
        if (!bus.full) begin
          if (!bus.req_valid[owner]) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = next_idx(owner);
          end else begin
            beat_cnt_nxt = beat_cnt + 8'd1;
            if (burst_done) begin
              state_nxt  = IDLE;
              rr_ptr_nxt = next_idx(owner);
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (!wrst) begin
      bus.busy = BURST_EN && (state == BURST);
      if (has_winner) begin
        bus.grant_id          = winner;
        bus.req_ready[winner] = !bus.full;
        bus.w_en              = !bus.full;
        for (int unsigned k = 0; k < NR; k++) begin
          if (32'(winner) == k) bus.wdata = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end
endmodule
